// File: rtl/addr_seq_pkg.sv
// Shared definitions for the address sweep controller: FSM states and
// default widths.
package addr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DWELL,
    WAIT_STEP,
    DONE
  } state_t;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DWELL_W = 4;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that paces auto-mode sweeps; expired flags the tick
// that arrives while the count is already zero.
module dwell_timer
  import addr_seq_pkg::*;
#(
  parameter int unsigned W = DWELL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = tick && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/addr_sweep_ctrl.sv
// Start/stop-controlled address sweep over [first_addr, last_addr], paced by
// divided ticks (auto) or step pulses (single-step), one read strobe per address.
module addr_sweep_ctrl
  import addr_seq_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DWELL_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          step,
  input  logic          tick,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  input  logic [DW-1:0] dwell,
  output logic [AW-1:0] addr,
  output logic          rd_en,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [AW-1:0] last_q;
  logic [DW-1:0] dwell_q;
  logic          mode_q;
  logic          launch;
  logic          addr_inc;
  logic          timer_load;
  logic          expired;

  dwell_timer #(.W(DW)) u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .tick    (tick),
    .value   (dwell_q),
    .expired (expired)
  );

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign rd_en = (state == READ);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    addr_inc   = 1'b0;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          launch    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (addr == last_q) begin
          state_nxt = DONE;
        end else if (mode_q) begin
          state_nxt = WAIT_STEP;
        end else begin
          timer_load = 1'b1;
          state_nxt  = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (expired) begin
          addr_inc  = 1'b1;
          state_nxt = READ;
        end
      end
      WAIT_STEP: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (step) begin
          addr_inc  = 1'b1;
          state_nxt = READ;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else if (launch) begin
      addr    <= first_addr;
      last_q  <= last_addr;
      dwell_q <= dwell;
      mode_q  <= mode;
    end else if (addr_inc) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
// Self-checking bench for addr_sweep_ctrl: directed scenarios plus randomized
// sweeps compared against read schedules derived from tick/step history.
module tb_addr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, mode, step, tick;
  logic [7:0] first_addr, last_addr;
  logic [3:0] dwell;
  logic [7:0] addr;
  logic       rd_en, busy, done;

  int errors = 0;
  int checks = 0;
  int gcyc   = 0;

  always #5 clk = ~clk;

  addr_sweep_ctrl #(.AW(8), .DW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .step       (step),
    .tick       (tick),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .dwell      (dwell),
    .addr       (addr),
    .rd_en      (rd_en),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge: outputs are sampled there, inputs driven after.
  task automatic nxt();
    @(negedge clk);
    gcyc++;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stop = 1'b0; step = 1'b0; tick = 1'b0;
  endtask

  // Runs one complete sweep with randomized pacing and scrambled config inputs,
  // then derives the expected read schedule from the recorded tick/step history.
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input logic md,
                           input logic [3:0] dw, input int per, input bit inject,
                           input string nm);
    int         rdc[$];
    logic [7:0] rda[$];
    int         dnc[$];
    bit         tq[$];
    bit         sq[$];
    int         exp_c[$];
    int         k;
    int         n;
    int         done_at = -1;
    logic [7:0] diff;
    logic [7:0] ea;
    logic       busy1 = 1'bx;
    logic       busy_after = 1'bx;
    logic [7:0] idle_addr = 8'hxx;

    diff = l - f;
    n = int'(diff) + 1;
    start = 1'b1; stop = 1'b0; step = 1'b0; tick = 1'b0;
    first_addr = f; last_addr = l; mode = md; dwell = dw;
    tq.push_back(1'b0);
    sq.push_back(1'b0);
    k = 0;
    while (k < 3000) begin
      nxt();
      k++;
      start = 1'b0;
      if (rd_en === 1'b1) begin
        rdc.push_back(k);
        rda.push_back(addr);
      end
      if (done === 1'b1) dnc.push_back(k);
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 1) busy1 = busy;
      if (done_at >= 0 && k == done_at + 1) busy_after = busy;
      if (done_at >= 0 && k == done_at + 3) begin
        idle_addr = addr;
        break;
      end
      first_addr = 8'($urandom);
      last_addr  = 8'($urandom);
      mode       = 1'($urandom);
      dwell      = 4'($urandom);
      if (inject && k == 2) start = 1'b1;
      tick = (per == 0) ? ($urandom_range(2, 0) == 0) : ((gcyc % per) == 0);
      step = !step && ($urandom_range(2, 0) == 0);
      if (done_at >= 0) begin
        tick = 1'b1;
        step = (k == done_at + 1);
      end
      tq.push_back(tick);
      sq.push_back(step);
    end
    clear_inputs();

    // Reference schedule: first read one cycle after start; each later read one
    // cycle after the (dwell+1)-th tick (auto) or first step (step mode) that
    // follows the previous read.
    exp_c.push_back(1);
    for (int j = 1; j < n; j++) begin
      int r;
      int need;
      int nx;
      r = exp_c[j-1];
      need = md ? 1 : int'(dw) + 1;
      nx = -1;
      for (int t = r + 1; t < tq.size(); t++) begin
        if (md ? sq[t] : tq[t]) need--;
        if (need == 0) begin
          nx = t + 1;
          break;
        end
      end
      exp_c.push_back(nx);
    end

    chk({nm, " read_count"}, rdc.size(), n);
    for (int j = 0; j < n && j < rdc.size(); j++) begin
      ea = f + 8'(j);
      chk($sformatf("%s read%0d_addr", nm, j), rda[j], ea);
      chk($sformatf("%s read%0d_cycle", nm, j), rdc[j], exp_c[j]);
    end
    chk({nm, " done_count"}, dnc.size(), 1);
    chk({nm, " done_cycle"}, done_at, exp_c[n-1] + 1);
    chk({nm, " busy_first"}, busy1, 1);
    chk({nm, " busy_after_done"}, busy_after, 0);
    chk({nm, " idle_addr"}, idle_addr, l);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    clear_inputs();
    mode = 1'b0; first_addr = '0; last_addr = '0; dwell = '0;
    #1;
    chk("reset addr", addr, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset done", done, 0);
    nxt();
    reset = 1'b0;
    nxt();

    run_sweep(8'h10, 8'h13, 1'b0, 4'd0, 4, 1'b0, "auto");
    run_sweep(8'hFE, 8'h01, 1'b1, 4'd0, 0, 1'b0, "wrap");
    run_sweep(8'h00, 8'h02, 1'b0, 4'd3, 1, 1'b0, "dwell");
    run_sweep(8'h33, 8'h33, 1'b0, 4'd2, 0, 1'b0, "single");

    // Abort during DWELL at address 05.
    start = 1'b1; first_addr = 8'h05; last_addr = 8'h20; mode = 1'b0; dwell = 4'd3;
    nxt();
    start = 1'b0;
    chk("abort_dwell read", rd_en, 1);
    chk("abort_dwell addr0", addr, 8'h05);
    nxt();
    chk("abort_dwell in_dwell", {busy, rd_en}, 2'b10);
    stop = 1'b1;
    nxt();
    stop = 1'b0;
    chk("abort_dwell busy", busy, 0);
    chk("abort_dwell addr", addr, 8'h05);
    chk("abort_dwell done", done, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      nxt();
      if (rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tick = 1'b0;
    chk("abort_dwell quiet", bad, 0);

    // Abort in READ: that read still happens, address freezes.
    start = 1'b1; first_addr = 8'h77; last_addr = 8'h90; mode = 1'b1;
    nxt();
    start = 1'b0;
    chk("abort_read rd_en", rd_en, 1);
    stop = 1'b1;
    nxt();
    stop = 1'b0;
    chk("abort_read busy", busy, 0);
    chk("abort_read addr", addr, 8'h77);
    chk("abort_read done", done, 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; first_addr = 8'hAA;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      clear_inputs();
      if (busy !== 1'b0 || rd_en !== 1'b0 || addr !== 8'h77) bad++;
    end
    chk("start_stop idle", bad, 0);

    run_sweep(8'h20, 8'h25, 1'b0, 4'd1, 0, 1'b1, "ignore");

    // Asynchronous reset mid-sweep.
    start = 1'b1; first_addr = 8'h40; last_addr = 8'h50; mode = 1'b1;
    nxt();
    start = 1'b0;
    chk("areset pre rd_en", rd_en, 1);
    chk("areset pre addr", addr, 8'h40);
    #1 reset = 1'b1;
    #1;
    chk("areset addr", addr, 0);
    chk("areset busy", busy, 0);
    chk("areset rd_en", rd_en, 0);
    #1 reset = 1'b0;
    nxt();
    chk("areset idle", busy, 0);
    run_sweep(8'h08, 8'h0B, 1'b0, 4'd2, 2, 1'b0, "post_reset");

    for (int s = 0; s < 6; s++) begin
      logic [7:0] rf;
      logic [7:0] span;
      logic       rm;
      span = 8'($urandom_range(7, 0));
      rf   = 8'($urandom);
      rm   = 1'($urandom);
      run_sweep(rf, rf + span, rm, 4'($urandom), $urandom_range(3, 0),
                (span != 0) && ($urandom_range(1, 0) == 1), $sformatf("rand%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addr_sweep_ctrl.md
# addr_sweep_ctrl

Controller that sequences the 8-bit memory address sweep used by the lab display datapath. It replaces a free-running address counter with a start/stop-controlled sweep over a programmable address window [first_addr, last_addr]. The sweep runs in auto mode, paced by a divided tick, or in single-step mode, paced by a step pulse. It issues a one-cycle read strobe per address and sits between the board I/O (buttons and switches, already debounced and pulsed) and the memory/display path.

## Interface
- AW, 8, address width; the sweep wraps modulo 2^AW
- DW, 4, dwell counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a sweep when idle
- stop  in  1  one-cycle pulse; aborts a sweep
- mode  in  1  0 = auto (tick-paced), 1 = single-step; sampled at start
- step  in  1  one-cycle pulse; advances the address in step mode
- tick  in  1  one-cycle enable from the clock divider; paces auto mode
- first_addr  in  AW  sweep start address; sampled at start
- last_addr  in  AW  sweep end address (inclusive); sampled at start
- dwell  in  DW  extra ticks spent per address in auto mode; sampled at start
- addr  out  AW  current memory address
- rd_en  out  1  one-cycle read strobe, valid with addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal sweep completion

## Operation
- States: IDLE, READ, DWELL, WAIT_STEP, DONE.
- IDLE:
  - addr holds its last value.
  - start=1 and stop=0: latch first/last/mode/dwell into internal registers, set addr<=first_addr, go to READ.
  - start and stop together while in IDLE: stop wins; the block stays in IDLE.
- READ: rd_en=1 for exactly this cycle, then:
  - addr==last_q: go to DONE.
  - else mode_q=1: go to WAIT_STEP.
  - else: load cnt<=dwell_q, go to DWELL.
- DWELL: on each tick, if cnt==0 then addr<=addr+1 and go to READ; otherwise cnt<=cnt-1. Non-tick cycles hold. dwell=0 advances on the first tick. dwell=N advances on tick N+1.
- WAIT_STEP: step=1 sets addr<=addr+1 and goes to READ. tick is ignored in this state.
- DONE: done=1 for one cycle, then go to IDLE. addr keeps last_q.
- Abort: stop=1 in READ, DWELL, or WAIT_STEP goes to IDLE on the next edge.
  - addr freezes at its current value.
  - done is not asserted.
  - In READ, the rd_en of that cycle still occurs.
- start while busy is ignored. Input changes to first/last/mode/dwell during a sweep have no effect.
- Address arithmetic is modulo 2^AW; 8'hFF increments to 8'h00.
- last_addr < first_addr is legal: the sweep wraps through 0.
- Reads per sweep = ((last−first) mod 2^AW) + 1. first==last gives exactly one read.

## Timing
- Reset values: state=IDLE, addr=0, rd_en=0, busy=0, done=0, cnt=0, latched config=0.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- start sampled at edge n: addr=first_addr, rd_en=1, and busy=1 during cycle n+1.
- Step mode: step at edge k gives addr+1 and rd_en=1 in cycle k+1.
- Auto mode: address period = (dwell+1) ticks plus 1 cycle per address.
- Final READ at cycle m: done=1 in cycle m+1, busy=0 from cycle m+2. A new start is accepted from cycle m+2.
- reset asserted mid-sweep forces the reset values immediately (asynchronous). After release the block waits in IDLE for a new start.

## Structure
- Shared package addr_seq_pkg holds:
  - the state enum (IDLE, READ, DWELL, WAIT_STEP, DONE);
  - default constants ADDR_W=8 and DWELL_W=4.
- One sub-module, dwell_timer:
  - loadable down-counter with inputs load, tick, and value;
  - output expired, asserted when a tick arrives with count==0.
- The FSM, address register, and config latches live in addr_sweep_ctrl.

## Test plan
- Auto sweep: first=8'h10, last=8'h13, dwell=0, mode=0, tick every 4 cycles → exactly 4 rd_en pulses at addr 10,11,12,13; one done pulse; addr holds 8'h13 in IDLE.
- Wrap sweep: first=8'hFE, last=8'h01, mode=1, three step pulses → reads at FE, FF, 00, 01; done after the 01 read; step pulses in IDLE change nothing.
- Dwell: first=0, last=2, dwell=3, tick every cycle → rd_en pulses exactly 5 cycles apart; 3 reads in total.
- Abort: stop during DWELL at addr 8'h05 → IDLE on the next cycle, addr=8'h05, no done. Start+stop together in IDLE → stays IDLE, no rd_en.
- Ignored inputs: a start pulse and a change of last_addr mid-sweep → sweep ends at the originally latched last; read count is unchanged.
- Async reset mid-sweep at addr 8'h40 → addr=0, busy=0, rd_en=0 with no clock edge; a new start after release runs normally.
